// File: rtl/sbox_layer_serializer_pkg.sv
// Shared definitions for the masked S-box layer serializer.
//   NIB, RW      : nibbles per state, fresh random bits per S-box evaluation
//   state_t      : controller states
//   SKINNY_SBOX  : unmasked SKINNY-64 S-box, nibble i holds S(i); used only by
//                  the behavioural S-box model, never by the controller
package sbox_layer_pkg;

  localparam int NIB = 16;
  localparam int RW  = 72;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [63:0] SKINNY_SBOX = 64'hF7E4_D583_B2A1_096C;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SKINNY_SBOX[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/sbox_layer_serializer_nibble_share_mux.sv
// Selects nibble idx of each of the three state shares, plus the share-1 and
// share-2 nibbles of the cyclic neighbour (idx+1, 15 wraps to 0).
// Every output is forced to 0 when en is low, so stale shares never toggle
// the S-box inputs.
//   sh1..sh3 : latched state shares
//   idx      : nibble index (0..15)
//   en       : issue flag
//   n1..n3   : selected share nibbles
//   nb       : {share2, share1} of the neighbouring nibble
module nibble_share_mux (
  input  logic [63:0] sh1,
  input  logic [63:0] sh2,
  input  logic [63:0] sh3,
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [3:0]  n1,
  output logic [3:0]  n2,
  output logic [3:0]  n3,
  output logic [7:0]  nb
);

  logic [3:0] nidx;

  always_comb begin
    // 4-bit add wraps 15 -> 0, which is exactly the neighbour rule
    nidx = idx + 4'd1;
    n1   = '0;
    n2   = '0;
    n3   = '0;
    nb   = '0;
    if (en) begin
      n1 = sh1[{idx, 2'b00} +: 4];
      n2 = sh2[{idx, 2'b00} +: 4];
      n3 = sh3[{idx, 2'b00} +: 4];
      nb = {sh2[{nidx, 2'b00} +: 4], sh1[{nidx, 2'b00} +: 4]};
    end
  end

endmodule

// File: rtl/sbox_layer_serializer.sv
// Pushes a 3-share masked 64-bit state through one masked 4-bit S-box, one
// nibble per cycle, and gathers the output shares after the S-box's single
// register stage. Shares stay in separate domains throughout.
//   clk, rst_i              : clock, async active-low reset
//   start, st1..st3         : load request and input shares
//   busy, done, res1..res3  : status and output shares (held until next done)
//   rnd, rnd_valid, rnd_ready : fresh randomness handshake
//   sb_in1..3, sb_nb, sb_r  : S-box request (zero when not issuing)
//   sb_out1..3              : S-box response, valid one clock after issue
//
// state | meaning
// IDLE  | waiting for start; busy=0
// RUN   | issuing nibbles when rnd_valid, capturing one edge later
// DONE  | results valid, done pulse, back to IDLE
module sbox_layer_serializer #(
  parameter int NIB = sbox_layer_pkg::NIB,
  parameter int RW  = sbox_layer_pkg::RW
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              start,
  input  logic [4*NIB-1:0]  st1,
  input  logic [4*NIB-1:0]  st2,
  input  logic [4*NIB-1:0]  st3,
  output logic              busy,
  output logic              done,
  output logic [4*NIB-1:0]  res1,
  output logic [4*NIB-1:0]  res2,
  output logic [4*NIB-1:0]  res3,
  input  logic [RW-1:0]     rnd,
  input  logic              rnd_valid,
  output logic              rnd_ready,
  output logic [3:0]        sb_in1,
  output logic [3:0]        sb_in2,
  output logic [3:0]        sb_in3,
  output logic [7:0]        sb_nb,
  output logic [RW-1:0]     sb_r,
  input  logic [3:0]        sb_out1,
  input  logic [3:0]        sb_out2,
  input  logic [3:0]        sb_out3
);

  import sbox_layer_pkg::*;

  localparam int SW = 4 * NIB;

  state_t          state, state_nxt;
  logic [SW-1:0]   sh1, sh2, sh3;
  logic [SW-1:0]   acc1, acc2, acc3;
  logic [4:0]      index;
  logic [3:0]      cap_idx;
  logic            pend;
  logic            issue;
  logic            load;
  logic            last_cap;
  logic [NIB-1:0]  wr_en;

  assign last_cap = pend && (cap_idx == 4'd15);

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    issue     = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy  = 1'b1;
        issue = rnd_valid && (index < 5'd16);
        if (last_cap) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rnd_ready = issue;
  assign sb_r      = issue ? rnd : '0;

  nibble_share_mux u_mux (
    .sh1 (sh1),
    .sh2 (sh2),
    .sh3 (sh3),
    .idx (index[3:0]),
    .en  (issue),
    .n1  (sb_in1),
    .n2  (sb_in2),
    .n3  (sb_in3),
    .nb  (sb_nb)
  );

  // One-hot write enable for the accumulator nibble being captured
  always_comb begin
    wr_en = '0;
    if (pend) wr_en[cap_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      sh1     <= '0;
      sh2     <= '0;
      sh3     <= '0;
      index   <= '0;
      cap_idx <= '0;
      pend    <= 1'b0;
    end else begin
      // The S-box register has no enable: the response is only valid on the
      // edge right after the issue, so pend tracks issue with no hold.
      pend <= issue;
      if (load) begin
        sh1   <= st1;
        sh2   <= st2;
        sh3   <= st3;
        index <= '0;
      end
      if (issue) begin
        index   <= index + 5'd1;
        cap_idx <= index[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      acc1 <= '0;
      acc2 <= '0;
      acc3 <= '0;
    end else begin
      for (int n = 0; n < NIB; n++) begin
        if (wr_en[n]) begin
          acc1[4*n +: 4] <= sb_out1;
          acc2[4*n +: 4] <= sb_out2;
          acc3[4*n +: 4] <= sb_out3;
        end
      end
    end
  end

  // The final capture is always nibble 15, so the result is the accumulator
  // with its top nibble taken straight from the S-box; this lands res in the
  // same edge that raises done.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      res1 <= '0;
      res2 <= '0;
      res3 <= '0;
    end else if (last_cap) begin
      res1 <= {sb_out1, acc1[SW-5:0]};
      res2 <= {sb_out2, acc2[SW-5:0]};
      res3 <= {sb_out3, acc3[SW-5:0]};
    end
  end

endmodule

// File: tb/tb_sbox_layer_serializer.sv
module tb_sbox_layer_serializer;
  import sbox_layer_pkg::*;

  logic          clk;
  logic          rst_i;
  logic          start;
  logic [63:0]   st1, st2, st3;
  logic          busy, done;
  logic [63:0]   res1, res2, res3;
  logic [71:0]   rnd;
  logic          rnd_valid;
  logic          rnd_ready;
  logic [3:0]    sb_in1, sb_in2, sb_in3;
  logic [7:0]    sb_nb;
  logic [71:0]   sb_r;
  logic [3:0]    sb_out1, sb_out2, sb_out3;

  int n_chk;
  int n_fail;

  sbox_layer_serializer dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .start     (start),
    .st1       (st1),
    .st2       (st2),
    .st3       (st3),
    .busy      (busy),
    .done      (done),
    .res1      (res1),
    .res2      (res2),
    .res3      (res3),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .sb_in1    (sb_in1),
    .sb_in2    (sb_in2),
    .sb_in3    (sb_in3),
    .sb_nb     (sb_nb),
    .sb_r      (sb_r),
    .sb_out1   (sb_out1),
    .sb_out2   (sb_out2),
    .sb_out3   (sb_out3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural masked S-box: one register, no enable; output shares
  // recombine to S(x) using two mask nibbles taken from the randomness.
  always_ff @(posedge clk) begin
    sb_out1 <= sbox4(sb_in1 ^ sb_in2 ^ sb_in3) ^ sb_r[3:0] ^ sb_r[7:4];
    sb_out2 <= sb_r[3:0];
    sb_out3 <= sb_r[7:4];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] nib(input logic [63:0] v, input int i);
    return v[4*i +: 4];
  endfunction

  task automatic chk_quiet(input string tag);
    chk({tag, ":busy"},  128'(busy), 128'(0));
    chk({tag, ":done"},  128'(done), 128'(0));
    chk({tag, ":rdy"},   128'(rnd_ready), 128'(0));
    chk({tag, ":res12"}, 128'({res1, res2}), 128'(0));
    chk({tag, ":res3"},  128'(res3), 128'(0));
    chk({tag, ":sb"},    128'({sb_in1, sb_in2, sb_in3, sb_nb, sb_r}), 128'(0));
  endtask

  // One operation: start edge E0, cycle k follows edge Ek. Expected issue
  // order, busy/done timing and recombined result are all derived here.
  task automatic run_op(input string nm, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] c, input logic [63:0] exp_x, input int exp_lat,
                        input logic [31:0] stall, input int dbl, input int rst_cyc);
    int   issued;
    int   rr_cnt;
    logic exp_iss;
    int   nn;
    issued = 0;
    rr_cnt = 0;
    @(posedge clk); #1;
    st1 = a; st2 = b; st3 = c; start = 1'b1; rnd_valid = 1'b0;
    for (int k = 0; k <= exp_lat + 2; k++) begin
      @(posedge clk); #1;
      st1 = ~a; st2 = ~b; st3 = ~c;
      start     = (k == dbl) || (k == exp_lat);
      rnd_valid = !stall[k];
      rnd       = {8'($urandom), $urandom, $urandom};
      if (k == rst_cyc) begin
        rst_i = 1'b0;
        #1;
        chk_quiet({nm, ":in_rst"});
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_i = 1'b1;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk);
          chk({nm, ":no_done"}, 128'({busy, done}), 128'(0));
        end
        return;
      end
      @(negedge clk);
      exp_iss = rnd_valid && (issued < 16) && (k < exp_lat);
      chk({nm, ":busy"}, 128'(busy), 128'(k < exp_lat));
      chk({nm, ":done"}, 128'(done), 128'(k == exp_lat));
      chk({nm, ":rdy"},  128'(rnd_ready), 128'(exp_iss));
      if (rnd_ready) rr_cnt++;
      if (exp_iss) begin
        nn = (issued + 1) % 16;
        chk({nm, ":sb_in"}, 128'({sb_in1, sb_in2, sb_in3}),
            128'({nib(a, issued), nib(b, issued), nib(c, issued)}));
        chk({nm, ":sb_nb"}, 128'(sb_nb), 128'({nib(b, nn), nib(a, nn)}));
        chk({nm, ":sb_r"},  128'(sb_r), 128'(rnd));
        issued++;
      end else begin
        chk({nm, ":sb_idle"}, 128'({sb_in1, sb_in2, sb_in3, sb_nb, sb_r}), 128'(0));
      end
      if (k == exp_lat || k == exp_lat + 2)
        chk({nm, ":res_xor"}, 128'(res1 ^ res2 ^ res3), 128'(exp_x));
    end
    chk({nm, ":rdy_count"}, 128'(rr_cnt), 128'(16));
  endtask

  logic [63:0] r_a, r_b;

  initial begin
    n_chk     = 0;
    n_fail    = 0;
    rst_i     = 1'b0;
    start     = 1'b0;
    st1       = '0;
    st2       = '0;
    st3       = '0;
    rnd       = '0;
    rnd_valid = 1'b0;
    #2;
    chk_quiet("reset");
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b1;

    run_op("zero", 64'h0, 64'h0, 64'h0, 64'hCCCC_CCCC_CCCC_CCCC, 17, 32'h0, -1, -1);

    r_a = {$urandom, $urandom};
    run_op("masked", 64'h0123_4567_89AB_CDEF, r_a, r_a,
           64'hC690_1A2B_385D_4E7F, 17, 32'h0, -1, -1);

    r_a = {$urandom, $urandom};
    run_op("stall", 64'h0123_4567_89AB_CDEF, r_a, r_a,
           64'hC690_1A2B_385D_4E7F, 20, 32'h0000_0818, -1, -1);

    r_a = {$urandom, $urandom};
    run_op("dbl_start", 64'h0123_4567_89AB_CDEF, r_a, r_a,
           64'hC690_1A2B_385D_4E7F, 17, 32'h0, 5, -1);

    r_a = {$urandom, $urandom};
    run_op("reset_mid", 64'h0123_4567_89AB_CDEF, r_a, r_a,
           64'hC690_1A2B_385D_4E7F, 17, 32'h0, -1, 9);

    r_a = {$urandom, $urandom};
    r_b = {$urandom, $urandom};
    run_op("post_rst", 64'hFEDC_BA98_7654_3210 ^ r_a ^ r_b, r_a, r_b,
           64'hF7E4_D583_B2A1_096C, 17, 32'h0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
